// File: rtl/warp_defines.sv
// Shared warp pipeline definitions: FU completion-port indices, default widths,
// pipe encodings and small helpers used by the writeback stage.
package warp_defines;

  localparam int unsigned WB_NUM_FU = 8;
  localparam int unsigned WB_XLEN   = 64;
  localparam int unsigned RD_W      = 5;

  localparam int unsigned FU_XARITH0 = 0;
  localparam int unsigned FU_XARITH1 = 1;
  localparam int unsigned FU_XLOGIC0 = 2;
  localparam int unsigned FU_XLOGIC1 = 3;
  localparam int unsigned FU_XSHIFT  = 4;
  localparam int unsigned FU_XMULTL  = 5;
  localparam int unsigned FU_XMULTH  = 6;
  localparam int unsigned FU_XDIV    = 7;

  typedef enum logic [2:0] {
    PIPE_ARITH = 3'd0,
    PIPE_LOGIC = 3'd1,
    PIPE_SHIFT = 3'd2,
    PIPE_MUL   = 3'd3,
    PIPE_DIV   = 3'd4
  } pipe_e;

  function automatic logic [31:0] rd_onehot(input logic [RD_W-1:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/warp_rr_arb2.sv
// Two-grant round-robin arbiter: first requester from ptr_i wins grant 0, the
// next requester with a different destination register wins grant 1.
module warp_rr_arb2
  import warp_defines::*;
#(
  parameter int unsigned NUM_FU = WB_NUM_FU,
  parameter int unsigned PTR_W  = 3
) (
  input  logic [NUM_FU-1:0]      req_i,
  input  logic [PTR_W-1:0]       ptr_i,
  input  logic [RD_W*NUM_FU-1:0] rd_i,
  output logic [NUM_FU-1:0]      gnt0_o,
  output logic [NUM_FU-1:0]      gnt1_o
);

  logic            have0;
  logic            have1;
  logic [RD_W-1:0] rd0;
  logic [PTR_W:0]  sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt0_o = '0;
    gnt1_o = '0;
    have0  = 1'b0;
    have1  = 1'b0;
    rd0    = '0;
    sum    = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      // Rotated index (ptr_i + i) mod NUM_FU without a divider.
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_FU)) begin
        sum = sum - (PTR_W+1)'(NUM_FU);
      end
      idx = sum[PTR_W-1:0];
      if (req_i[idx]) begin
        if (!have0) begin
          gnt0_o[idx] = 1'b1;
          have0       = 1'b1;
          rd0         = rd_i[RD_W*idx +: RD_W];
        end else if (!have1 && (rd_i[RD_W*idx +: RD_W] != rd0)) begin
          gnt1_o[idx] = 1'b1;
          have1       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/warp_writeback.sv
// Writeback stage: arbitrates FU completions onto two register-file write ports
// and clears reservations. Optional perf counters under WARP_WB_PERF_EN.
module warp_writeback
  import warp_defines::*;
#(
  parameter int unsigned NUM_FU = WB_NUM_FU,
  parameter int unsigned XLEN   = WB_XLEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_FU-1:0]      i_fu_valid,
  output logic [NUM_FU-1:0]      o_fu_ready,
  input  logic [RD_W*NUM_FU-1:0] i_fu_rd,
  input  logic [XLEN*NUM_FU-1:0] i_fu_data,
  output logic                   o_wr0_en,
  output logic [4:0]             o_wr0_addr,
  output logic [XLEN-1:0]        o_wr0_data,
  output logic                   o_wr1_en,
  output logic [4:0]             o_wr1_addr,
  output logic [XLEN-1:0]        o_wr1_data,
  output logic [31:0]            o_resv_clear
`ifdef WARP_WB_PERF_EN
  ,
  output logic [31:0]            o_perf_retired,
  output logic [31:0]            o_perf_stall
`endif
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] gnt0, gnt1, gnt_all;
  logic [PTR_W-1:0]  idx0, idx1, last_idx;
  logic [RD_W-1:0]   rd0, rd1;
  logic [XLEN-1:0]   data0, data1;
  logic              any0, any1;

  logic              wr0_en_q, wr0_en_d;
  logic [4:0]        wr0_addr_q, wr0_addr_d;
  logic [XLEN-1:0]   wr0_data_q, wr0_data_d;
  logic              wr1_en_q, wr1_en_d;
  logic [4:0]        wr1_addr_q, wr1_addr_d;
  logic [XLEN-1:0]   wr1_data_q, wr1_data_d;
  logic [31:0]       resv_q, resv_d;

  warp_rr_arb2 #(
    .NUM_FU(NUM_FU),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (i_fu_valid),
    .ptr_i (rr_ptr_q),
    .rd_i  (i_fu_rd),
    .gnt0_o(gnt0),
    .gnt1_o(gnt1)
  );

  assign gnt_all    = gnt0 | gnt1;
  assign o_fu_ready = i_rst ? '0 : gnt_all;
  assign any0       = |gnt0;
  assign any1       = |gnt1;

  always_comb begin
    idx0  = '0;
    idx1  = '0;
    rd0   = '0;
    rd1   = '0;
    data0 = '0;
    data1 = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      if (gnt0[k]) begin
        idx0  = PTR_W'(k);
        rd0   = i_fu_rd[RD_W*k +: RD_W];
        data0 = i_fu_data[XLEN*k +: XLEN];
      end
      if (gnt1[k]) begin
        idx1  = PTR_W'(k);
        rd1   = i_fu_rd[RD_W*k +: RD_W];
        data1 = i_fu_data[XLEN*k +: XLEN];
      end
    end
  end

  // Grant 1 is always later in rotated order, so it is the last granted index.
  assign last_idx = any1 ? idx1 : idx0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any0) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_FU-1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_comb begin
    wr0_en_d   = any0 && (rd0 != '0);
    wr0_addr_d = any0 ? rd0 : '0;
    wr0_data_d = any0 ? data0 : '0;
    wr1_en_d   = any1 && (rd1 != '0);
    wr1_addr_d = any1 ? rd1 : '0;
    wr1_data_d = any1 ? data1 : '0;
    resv_d     = '0;
    if (any0) resv_d = resv_d | rd_onehot(rd0);
    if (any1) resv_d = resv_d | rd_onehot(rd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q   <= '0;
      wr0_en_q   <= 1'b0;
      wr0_addr_q <= '0;
      wr0_data_q <= '0;
      wr1_en_q   <= 1'b0;
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
      resv_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr0_en_q   <= wr0_en_d;
      wr0_addr_q <= wr0_addr_d;
      wr0_data_q <= wr0_data_d;
      wr1_en_q   <= wr1_en_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      resv_q     <= resv_d;
    end
  end

  assign o_wr0_en     = wr0_en_q;
  assign o_wr0_addr   = wr0_addr_q;
  assign o_wr0_data   = wr0_data_q;
  assign o_wr1_en     = wr1_en_q;
  assign o_wr1_addr   = wr1_addr_q;
  assign o_wr1_data   = wr1_data_q;
  assign o_resv_clear = resv_q;

`ifdef WARP_WB_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q + 32'(any0) + 32'(any1);
    stall_d   = stall_q;
    if (|(i_fu_valid & ~gnt_all)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign o_perf_retired = retired_q;
  assign o_perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_warp_writeback.sv
// Self-checking bench for warp_writeback: directed scenarios plus random
// completion traffic against a queue-based reference model.
module tb_warp_writeback;

  localparam int NFU = 8;
  localparam int XL  = 64;

  logic              clk;
  logic              i_rst;
  logic [NFU-1:0]    i_fu_valid;
  logic [NFU-1:0]    o_fu_ready;
  logic [5*NFU-1:0]  i_fu_rd;
  logic [XL*NFU-1:0] i_fu_data;
  logic              o_wr0_en, o_wr1_en;
  logic [4:0]        o_wr0_addr, o_wr1_addr;
  logic [XL-1:0]     o_wr0_data, o_wr1_data;
  logic [31:0]       o_resv_clear;
`ifdef WARP_WB_PERF_EN
  logic [31:0]       o_perf_retired, o_perf_stall;
`endif

  warp_writeback #(.NUM_FU(NFU), .XLEN(XL)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_fu_valid  (i_fu_valid),
    .o_fu_ready  (o_fu_ready),
    .i_fu_rd     (i_fu_rd),
    .i_fu_data   (i_fu_data),
    .o_wr0_en    (o_wr0_en),
    .o_wr0_addr  (o_wr0_addr),
    .o_wr0_data  (o_wr0_data),
    .o_wr1_en    (o_wr1_en),
    .o_wr1_addr  (o_wr1_addr),
    .o_wr1_data  (o_wr1_data),
    .o_resv_clear(o_resv_clear)
`ifdef WARP_WB_PERF_EN
    ,
    .o_perf_retired(o_perf_retired),
    .o_perf_stall  (o_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending result per unit, round-robin pointer, expectations.
  int          ptr_m;
  bit          pv   [NFU];
  logic [4:0]  prd  [NFU];
  logic [63:0] pdat [NFU];
  bit          e_en0, e_en1;
  logic [4:0]  e_a0, e_a1;
  logic [63:0] e_d0, e_d1;
  logic [31:0] e_clr;
  logic [31:0] e_ret, e_stall;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":wr0_en"}, 64'(o_wr0_en), 64'(e_en0));
    if (e_en0) begin
      chk({where, ":wr0_addr"}, 64'(o_wr0_addr), 64'(e_a0));
      chk({where, ":wr0_data"}, o_wr0_data, e_d0);
    end
    chk({where, ":wr1_en"}, 64'(o_wr1_en), 64'(e_en1));
    if (e_en1) begin
      chk({where, ":wr1_addr"}, 64'(o_wr1_addr), 64'(e_a1));
      chk({where, ":wr1_data"}, o_wr1_data, e_d1);
    end
    chk({where, ":resv_clear"}, 64'(o_resv_clear), 64'(e_clr));
`ifdef WARP_WB_PERF_EN
    chk({where, ":perf_retired"}, 64'(o_perf_retired), 64'(e_ret));
    chk({where, ":perf_stall"}, 64'(o_perf_stall), 64'(e_stall));
`endif
  endtask

  task automatic drive();
    for (int k = 0; k < NFU; k++) begin
      i_fu_valid[k]          = pv[k];
      i_fu_rd[5*k +: 5]      = prd[k];
      i_fu_data[XL*k +: XL]  = pdat[k];
    end
  endtask

  // One clock: check last cycle's writes, present pending results, predict grants.
  task automatic step(input string where);
    int          order[$];
    int          g0, g1;
    logic [7:0]  er;
    @(negedge clk);
    check_outputs(where);
    drive();
    #1;
    g0 = -1;
    g1 = -1;
    for (int i = 0; i < NFU; i++) order.push_back((ptr_m + i) % NFU);
    foreach (order[j]) begin
      if (pv[order[j]]) begin
        if (g0 < 0) g0 = order[j];
        else if (g1 < 0 && prd[order[j]] != prd[g0]) g1 = order[j];
      end
    end
    er = '0;
    if (g0 >= 0) er[g0] = 1'b1;
    if (g1 >= 0) er[g1] = 1'b1;
    chk({where, ":ready"}, 64'(o_fu_ready), 64'(er));
    for (int k = 0; k < NFU; k++) begin
      if (pv[k] && !er[k]) begin
        e_stall = e_stall + 1;
        break;
      end
    end
    e_clr = '0;
    e_en0 = (g0 >= 0) && (prd[g0] != 0);
    e_en1 = (g1 >= 0) && (prd[g1] != 0);
    if (g0 >= 0) begin
      e_a0 = prd[g0]; e_d0 = pdat[g0]; e_clr[prd[g0]] = 1'b1; e_ret = e_ret + 1; pv[g0] = 0;
    end
    if (g1 >= 0) begin
      e_a1 = prd[g1]; e_d1 = pdat[g1]; e_clr[prd[g1]] = 1'b1; e_ret = e_ret + 1; pv[g1] = 0;
    end
    if (g1 >= 0)      ptr_m = (g1 + 1) % NFU;
    else if (g0 >= 0) ptr_m = (g0 + 1) % NFU;
  endtask

  task automatic clear_exp();
    e_en0 = 0; e_en1 = 0; e_a0 = '0; e_a1 = '0; e_d0 = '0; e_d1 = '0;
    e_clr = '0; e_ret = '0; e_stall = '0;
  endtask

  // Asynchronous reset: checked before any clock edge, then held across one edge.
  task automatic do_reset(input string where);
    i_rst = 1'b1;
    #1;
    chk({where, ":ready"},    64'(o_fu_ready), 64'(0));
    chk({where, ":wr0_en"},   64'(o_wr0_en), 64'(0));
    chk({where, ":wr0_addr"}, 64'(o_wr0_addr), 64'(0));
    chk({where, ":wr0_data"}, o_wr0_data, 64'(0));
    chk({where, ":wr1_en"},   64'(o_wr1_en), 64'(0));
    chk({where, ":wr1_addr"}, 64'(o_wr1_addr), 64'(0));
    chk({where, ":wr1_data"}, o_wr1_data, 64'(0));
    chk({where, ":resv"},     64'(o_resv_clear), 64'(0));
    ptr_m = 0;
    for (int k = 0; k < NFU; k++) pv[k] = 0;
    clear_exp();
    @(posedge clk);
    #1;
    check_outputs({where, "_hold"});
    chk({where, ":ready_hold"}, 64'(o_fu_ready), 64'(0));
    @(negedge clk);
    i_rst = 1'b0;
    drive();
  endtask

  task automatic set_fu(input int k, input logic [4:0] rd, input logic [63:0] d);
    pv[k] = 1; prd[k] = rd; pdat[k] = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_rst    = 1'b0;
    for (int k = 0; k < NFU; k++) begin
      pv[k] = 0; prd[k] = '0; pdat[k] = '0;
    end
    drive();
    #2;
    do_reset("por");

    // Two units from pointer 0: ports filled in rotated order, pointer ends at 7.
    set_fu(1, 5'd3, 64'hA);
    set_fu(6, 5'd9, 64'hB);
    step("pair");
    step("pair_wb");
    // Pointer at 7 means unit 7 takes port 0 ahead of unit 0.
    set_fu(0, 5'd12, 64'h1111);
    set_fu(7, 5'd13, 64'h7777);
    step("ptr7");
    step("ptr7_wb");

    // Move pointer to 6, then all eight units valid for four cycles.
    set_fu(5, 5'd20, 64'h55);
    step("to6");
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < NFU; k++) set_fu(k, 5'(k + 1), {$urandom, $urandom});
      step($sformatf("all8_%0d", c));
    end
    for (int k = 0; k < NFU; k++) pv[k] = 0;
    step("all8_wb");

    // rd==0: write suppressed, reservation bit 0 still pulses.
    set_fu(4, 5'd0, 64'hDEAD);
    step("rd0");
    step("rd0_wb");

    // Reset mid-stream while units 2 and 5 are valid and writes are in flight.
    set_fu(2, 5'd17, 64'h22);
    set_fu(5, 5'd18, 64'h55);
    step("pre_rst");
    set_fu(2, 5'd17, 64'h22);
    set_fu(5, 5'd18, 64'h55);
    drive();
    @(posedge clk);
    #2;
    do_reset("mid_rst");
    step("post_rst0");
    step("post_rst1");

    // Same-rd collision: unit 1 deferred behind unit 0, unit 3 takes port 1.
    set_fu(0, 5'd4, 64'h40);
    set_fu(1, 5'd4, 64'h41);
    set_fu(3, 5'd7, 64'h73);
    step("coll0");
    step("coll1");
    step("coll_wb");

    // Random completion traffic; units hold results until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NFU; k++) begin
        if (!pv[k] && ($urandom_range(0, 99) < 55)) begin
          set_fu(k, 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end
      end
      step("rand");
    end
    for (int c = 0; c < 12; c++) step("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
